// File: rtl/rr_channel_mux_pkg.sv
// Shared defaults and arbitration mode encodings for the round-robin channel mux.
package rr_channel_mux_pkg;

  localparam int N_CH_DEFAULT  = 4;
  localparam int WIDTH_DEFAULT = 8;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/rr_channel_mux_grant_picker.sv
// Combinational grant selection: rotating scan from ptr, or lowest index in fixed mode.
module rr_grant_picker
  import rr_channel_mux_pkg::*;
#(
  parameter int N_CH = N_CH_DEFAULT,
  parameter int PW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            mode,
  output logic [N_CH-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 0; k < N_CH; k++) begin
      // In fixed mode the scan origin is pinned at channel 0.
      c = (mode == MODE_FIXED) ? k : (int'(ptr) + k) % N_CH;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = c[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_channel_mux.sv
// N-channel arbiter feeding a single registered output slot with valid/ready handshake.
module rr_channel_mux
  import rr_channel_mux_pkg::*;
#(
  parameter int N_CH  = N_CH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  localparam int PW   = $clog2(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [N_CH-1:0]            in_valid,
  input  logic [N_CH-1:0][WIDTH-1:0] in_data,
  output logic [N_CH-1:0]            in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [PW-1:0]              out_ch,
  input  logic                       out_ready
);

  logic [PW-1:0]   ptr;
  logic [N_CH-1:0] grant;
  logic [PW-1:0]   gidx;
  logic            gany;
  logic            can_load;
  logic            xfer;

  rr_grant_picker #(
    .N_CH (N_CH),
    .PW   (PW)
  ) u_picker (
    .req   (in_valid),
    .ptr   (ptr),
    .mode  (mode),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  assign can_load = !out_valid || out_ready;
  // Reset blocks the handshake so a word is never accepted and then discarded.
  assign xfer     = gany && can_load && !rst;
  assign in_ready = xfer ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gidx];
      out_ch    <= gidx;
      if (mode == MODE_RR)
        ptr <= (gidx == PW'(N_CH - 1)) ? '0 : gidx + PW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_channel_mux.sv
// Directed bench for rr_channel_mux with a per-cycle reference model and an ordering scoreboard.
module tb_rr_channel_mux;
  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic [N-1:0]     in_valid;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [1:0]       out_ch;
  logic             out_ready;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int         m_ptr;
  logic       m_v;
  logic [7:0] m_d;
  int         m_ch;
  logic [9:0] sb[$];

  rr_channel_mux #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the negedge: compare DUT against the model, then step the model.
  task automatic model_cycle();
    logic [3:0] er;
    logic [9:0] front;
    int g;
    int c;
    er = '0;
    g  = -1;
    if (!rst && (!m_v || out_ready)) begin
      if (mode) begin
        for (int i = N - 1; i >= 0; i--) if (in_valid[i]) g = i;
      end else begin
        c = m_ptr;
        for (int k = 0; k < N && g < 0; k++) begin
          if (in_valid[c]) g = c;
          c = (c + 1 == N) ? 0 : c + 1;
        end
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("in_ready",  32'(in_ready),  32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_v));
    chk("out_data",  32'(out_data),  32'(m_d));
    chk("out_ch",    32'(out_ch),    32'(m_ch));

    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_empty_pop", 32'(sb.size()), 32'd1);
      end else begin
        front = sb.pop_front();
        chk("sb_order", {22'd0, out_ch, out_data}, {22'd0, front});
      end
    end
    if (!rst && |(in_valid & in_ready))
      for (int i = 0; i < N; i++)
        if (in_valid[i] && in_ready[i]) sb.push_back({2'(i), in_data[i]});

    if (rst) begin
      m_v = 1'b0; m_d = '0; m_ch = 0; m_ptr = 0;
      sb.delete();
    end else if (g >= 0) begin
      m_v = 1'b1; m_d = in_data[g]; m_ch = g;
      if (!mode) m_ptr = (g + 1) % N;
    end else if (m_v && out_ready) begin
      m_v = 1'b0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_data();
    for (int i = 0; i < N; i++) in_data[i] = 8'(8'h10 + i);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = '0; out_ready = 1'b1;
    set_default_data();
    @(posedge clk);
    #1;
    m_v = 1'b0; m_d = '0; m_ch = 0; m_ptr = 0;
    rst = 1'b0;

    // reset state
    sample();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    advance();

    // single channel request
    in_valid = 4'b0100; in_data[2] = 8'hA5;
    sample();
    chk("single_in_ready", 32'(in_ready), 32'h4);
    advance();
    in_valid = '0;
    sample();
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data",  32'(out_data),  32'hA5);
    chk("single_out_ch",    32'(out_ch),    32'd2);
    advance();
    set_default_data();
    sample();
    advance();

    // all requesting, round robin
    pulse_reset();
    in_valid = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      sample();
      if (j > 0) begin
        chk("rr_seq_ch",   32'(out_ch),   32'((j - 1) % 4));
        chk("rr_seq_data", 32'(out_data), 32'(8'h10 + (j - 1) % 4));
      end
      advance();
    end

    // fixed priority; ptr must be left at 0
    mode = 1'b1;
    for (int j = 0; j < 5; j++) begin
      sample();
      chk("fixed_in_ready", 32'(in_ready), 32'h1);
      if (j > 0) chk("fixed_out_ch", 32'(out_ch), 32'd0);
      advance();
    end
    mode = 1'b0;
    sample();
    chk("ptr_kept_in_ready", 32'(in_ready), 32'h1);
    advance();

    // backpressure
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      sample();
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_out_data", 32'(out_data), 32'h10);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      advance();
    end
    out_ready = 1'b1;
    sample();
    chk("release_in_ready", 32'(in_ready), 32'h2);
    advance();

    // wrap: ptr to 3, then requests on 1 and 3
    in_valid = 4'b0100;
    sample();
    chk("release_out_ch",   32'(out_ch),   32'd1);
    chk("release_out_data", 32'(out_data), 32'h11);
    advance();
    in_valid = 4'b1010;
    sample();
    chk("wrap_first", 32'(in_ready), 32'h8);
    advance();
    sample();
    chk("wrap_second", 32'(in_ready), 32'h2);
    chk("wrap_out_ch", 32'(out_ch),   32'd3);
    advance();

    // reset while holding a word
    in_valid = 4'b1111; out_ready = 1'b0;
    sample();
    advance();
    rst = 1'b1;
    sample();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    advance();
    rst = 1'b0;
    sample();
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_out_ch",    32'(out_ch),    32'd0);
    chk("post_rst_grant",     32'(in_ready),  32'h1);
    advance();
    out_ready = 1'b1;

    // mixed traffic
    for (int j = 0; j < 80; j++) begin
      in_valid  = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = ($urandom_range(0, 4) == 0);
      rst       = ($urandom_range(0, 24) == 0);
      for (int i = 0; i < N; i++) in_data[i] = 8'($urandom);
      sample();
      advance();
    end
    rst = 1'b0; in_valid = '0; out_ready = 1'b1;
    sample();
    advance();
    sample();
    advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_channel_mux.md
RR_CHANNEL_MUX -- requirements
Module: rr_channel_mux

Interface
REQ-001 Parameter N_CH, default 4, number of input channels; legal range 2..16.
REQ-002 Parameter WIDTH, default 8, data width per channel in bits.
REQ-003 Port clk, input, 1, the single clock; every register is updated on its rising edge.
REQ-004 Port rst, input, 1, the reset; synchronous and active-high.
REQ-005 Port mode, input, 1, arbitration mode: 0 = round-robin, 1 = fixed priority with channel 0 highest.
REQ-006 Port in_valid, input, N_CH, per-channel request.
REQ-007 Port in_data, input, N_CH x WIDTH, per-channel payload.
REQ-008 Port in_ready, output, N_CH, per-channel accept; at most one bit is high per cycle.
REQ-009 Port out_valid, output, 1, the output register holds a word.
REQ-010 Port out_data, output, WIDTH, the registered payload.
REQ-011 Port out_ch, output, $clog2(N_CH), index of the channel that sourced out_data.
REQ-012 Port out_ready, input, 1, the downstream accepts the word.

Function
REQ-013 The output stage is a single register, with can_load = !out_valid | out_ready.
REQ-014 A transfer occurs on channel i in any cycle where in_valid[i] & in_ready[i] are both high.
REQ-015 in_ready[i] is high only when can_load is high and channel i is the grant winner; in_ready is combinational from in_valid, mode, ptr and out_ready.
REQ-016 Grant search in round-robin mode: scan channels ptr, ptr+1, ..., wrapping modulo N_CH; the first channel with in_valid high wins.
REQ-017 Grant search in fixed-priority mode: the lowest-index channel with in_valid high wins; ptr is ignored.
REQ-018 On a transfer from channel g: out_data <= in_data[g], out_ch <= g and out_valid <= 1 on the next edge, giving a latency of 1 cycle.
REQ-019 On a transfer from channel g in round-robin mode: ptr <= g+1, wrapping from N_CH-1 to 0.
REQ-020 On a transfer in fixed-priority mode, ptr is left unchanged.
REQ-021 When out_valid & out_ready are high and no transfer occurs, out_valid <= 0; out_data and out_ch hold their values.
REQ-022 When out_valid is high and out_ready is low, out_data, out_ch and ptr hold, and all in_ready bits are 0 (backpressure).
REQ-023 A simultaneous drain and load (out_ready high while a grant exists) reloads the register in the same cycle, sustaining 1 word per clock.
REQ-024 When no in_valid bit is high, all in_ready bits are 0 and ptr holds.
REQ-025 A change of mode takes effect combinationally in that same cycle and does not reset ptr.
REQ-026 No word is dropped or duplicated; every accepted input appears exactly once on the output, in acceptance order.

Reset
REQ-027 While rst is high at a clock edge: out_valid <= 0, out_data <= 0, out_ch <= 0 and ptr <= 0.
REQ-028 While rst is high, all in_ready bits are 0; reset asserted mid-transfer discards the held word, and no handshake completes in that cycle.
REQ-029 In the first cycle after rst falls, arbitration starts from channel 0.

Structure
REQ-030 A package rr_channel_mux_pkg holds the default N_CH and WIDTH values and the mode constants MODE_RR=0 and MODE_FIXED=1.
REQ-031 Grant selection is a combinational sub-module rr_grant_picker with inputs req[N_CH], ptr and mode, and outputs a one-hot grant and its encoded index.
REQ-032 The top-level module holds only ptr, the output register and the handshake logic.

Verification
REQ-033 Single channel, N_CH=4, WIDTH=8, mode=0: in_valid=4'b0100 with data 8'hA5 and out_ready=1 -> in_ready=4'b0100, and next cycle out_valid=1, out_data=8'hA5, out_ch=2.
REQ-034 All channels requesting, mode=0, out_ready=1, data = 8'h10+i -> out_ch sequence 0,1,2,3,0,... on consecutive clocks, 1 word per clock.
REQ-035 All channels requesting, mode=1 -> out_ch stays 0 every cycle, and ptr is unchanged.
REQ-036 out_ready held 0 for 5 cycles with out_valid=1 -> out_data stable and in_ready=0 throughout; on release, the held word drains and the next grant loads in the same cycle.
REQ-037 ptr=3 with requests on channels 1 and 3, mode=0 -> channel 3 wins, then ptr wraps to 0 and channel 1 wins next.
REQ-038 rst asserted while out_valid=1 -> next cycle out_valid=0, out_ch=0, ptr=0, and the first grant after release goes to channel 0.
